// File: rtl/geofence_n_pkg.sv
// geofence_pkg: shared FSM state type, cross-product width helper and NUM_V bounds.
package geofence_pkg;
  typedef enum logic [1:0] {LOAD, SORT, CHECK, DONE} state_t;
  localparam int NUM_V_MIN = 3;
  localparam int NUM_V_MAX = 8;
  function automatic int cross_w(input int coord_w);
    return 2 * coord_w + 3;
  endfunction
endpackage

// File: rtl/geofence_n_if.sv
// geofence_n_if: beat input and result bus of geofence_n.
interface geofence_n_if #(parameter int COORD_W = 10);
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic               valid;
  logic               is_inside;
  logic               on_edge;
  modport master (output in_valid, X, Y, input in_ready, valid, is_inside, on_edge);
  modport slave  (input in_valid, X, Y, output in_ready, valid, is_inside, on_edge);
endinterface

// File: rtl/geofence_n_cross.sv
// geofence_cross: signed cross product (a-o) x (b-o) at full precision, combinational.
module geofence_cross import geofence_pkg::*; #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0]                ox,
  input  logic [COORD_W-1:0]                oy,
  input  logic [COORD_W-1:0]                ax,
  input  logic [COORD_W-1:0]                ay,
  input  logic [COORD_W-1:0]                bx,
  input  logic [COORD_W-1:0]                by,
  output logic signed [cross_w(COORD_W)-1:0] c
);
  localparam int DW = COORD_W + 1;
  localparam int CW = cross_w(COORD_W);
  logic signed [DW-1:0] dax, day, dbx, dby;
  assign dax = $signed({1'b0, ax}) - $signed({1'b0, ox});
  assign day = $signed({1'b0, ay}) - $signed({1'b0, oy});
  assign dbx = $signed({1'b0, bx}) - $signed({1'b0, ox});
  assign dby = $signed({1'b0, by}) - $signed({1'b0, oy});
  assign c = CW'(dax) * CW'(dby) - CW'(day) * CW'(dbx);
endmodule

// File: rtl/geofence_n.sv
// geofence_n: convex-polygon containment of a target point (load, CCW bubble sort, edge check).
// Define GEOFENCE_EDGE_EN for boundary-inclusive is_inside and a live on_edge flag.
module geofence_n import geofence_pkg::*; #(
  parameter int COORD_W = 10,
  parameter int NUM_V   = 6
) (
  input logic         clk,
  input logic         reset,
  geofence_n_if.slave bus
);
  localparam int CW = cross_w(COORD_W);
  localparam int AW = $clog2(NUM_V);
  localparam int LW = $clog2(NUM_V + 1);
  localparam logic [AW-1:0] K_LAST = AW'(NUM_V - 2);
  localparam logic [AW-1:0] P_LAST = AW'(NUM_V - 3);
  localparam logic [AW-1:0] E_LAST = AW'(NUM_V - 1);
  localparam logic [LW-1:0] L_LAST = LW'(NUM_V);

  if (NUM_V < NUM_V_MIN || NUM_V > NUM_V_MAX) begin : g_bad_num_v
    $error("geofence_n: NUM_V out of range");
  end

  state_t             state_q, state_d;
  logic [LW-1:0]      ld_q, ld_d;
  logic [AW-1:0]      idx_q, idx_d, pass_q, pass_d, k1;
  logic               all_q, all_d, valid_q, valid_d, inside_q, inside_d;
  logic [COORD_W-1:0] vx_q [NUM_V];
  logic [COORD_W-1:0] vy_q [NUM_V];
  logic [COORD_W-1:0] vx_d [NUM_V];
  logic [COORD_W-1:0] vy_d [NUM_V];
  logic [COORD_W-1:0] tx_q, ty_q, tx_d, ty_d;
  logic [COORD_W-1:0] ox, oy, ax, ay, bx, by;
  logic signed [CW-1:0] c;
  logic               accept, ok;

  assign bus.in_ready  = state_q == LOAD;
  assign bus.valid     = valid_q;
  assign bus.is_inside = inside_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // SORT compares V[idx] and V[idx+1] about V[0]; CHECK tests edge V[idx]->V[idx+1 mod N] against T
  assign k1 = (state_q == SORT || idx_q != E_LAST) ? idx_q + 1'b1 : '0;
  assign ox = state_q == SORT ? vx_q[0] : vx_q[idx_q];
  assign oy = state_q == SORT ? vy_q[0] : vy_q[idx_q];
  assign ax = state_q == SORT ? vx_q[idx_q] : vx_q[k1];
  assign ay = state_q == SORT ? vy_q[idx_q] : vy_q[k1];
  assign bx = state_q == SORT ? vx_q[k1] : tx_q;
  assign by = state_q == SORT ? vy_q[k1] : ty_q;

  geofence_cross #(.COORD_W(COORD_W)) u_cross (
    .ox(ox), .oy(oy), .ax(ax), .ay(ay), .bx(bx), .by(by), .c(c)
  );

`ifdef GEOFENCE_EDGE_EN
  logic zero_q, zero_d, edge_q, edge_d;
  assign ok          = !c[CW-1];
  assign bus.on_edge = edge_q;
`else
  assign ok          = !c[CW-1] && |c;
  assign bus.on_edge = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    all_d    = all_q;
    valid_d  = 1'b0;
    inside_d = inside_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
`ifdef GEOFENCE_EDGE_EN
    zero_d   = zero_q;
    edge_d   = edge_q;
`endif
    case (state_q)
      LOAD: if (accept) begin
        if (ld_q == '0) begin
          tx_d = bus.X;
          ty_d = bus.Y;
        end else begin
          vx_d[AW'(ld_q - 1'b1)] = bus.X;
          vy_d[AW'(ld_q - 1'b1)] = bus.Y;
        end
        ld_d = ld_q == L_LAST ? '0 : ld_q + 1'b1;
        if (ld_q == L_LAST) begin
          state_d = SORT;
          idx_d   = AW'(1);
          pass_d  = '0;
        end
      end
      SORT: begin
        if (c[CW-1]) begin
          vx_d[idx_q] = vx_q[k1];
          vy_d[idx_q] = vy_q[k1];
          vx_d[k1]    = vx_q[idx_q];
          vy_d[k1]    = vy_q[idx_q];
        end
        idx_d = idx_q == K_LAST ? AW'(1) : idx_q + 1'b1;
        if (idx_q == K_LAST) begin
          pass_d = pass_q + 1'b1;
          if (pass_q == P_LAST) begin
            state_d = CHECK;
            idx_d   = '0;
            pass_d  = '0;
            all_d   = 1'b1;
`ifdef GEOFENCE_EDGE_EN
            zero_d  = 1'b0;
`endif
          end
        end
      end
      CHECK: begin
        all_d = all_q && ok;
        idx_d = idx_q + 1'b1;
`ifdef GEOFENCE_EDGE_EN
        zero_d = zero_q || c == '0;
`endif
        if (idx_q == E_LAST) begin
          state_d  = DONE;
          idx_d    = '0;
          valid_d  = 1'b1;
          inside_d = all_d;
`ifdef GEOFENCE_EDGE_EN
          edge_d   = all_d && zero_d;
`endif
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      ld_q     <= '0;
      idx_q    <= '0;
      pass_q   <= '0;
      all_q    <= 1'b0;
      valid_q  <= 1'b0;
      inside_q <= 1'b0;
`ifdef GEOFENCE_EDGE_EN
      zero_q   <= 1'b0;
      edge_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ld_q     <= ld_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      all_q    <= all_d;
      valid_q  <= valid_d;
      inside_q <= inside_d;
`ifdef GEOFENCE_EDGE_EN
      zero_q   <= zero_d;
      edge_q   <= edge_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    vx_q <= vx_d;
    vy_q <= vy_d;
    tx_q <= tx_d;
    ty_q <= ty_d;
  end
endmodule
